// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
//   Front end for the six-button watch UI. Each raw active-low button is
//   synchronised, debounced and turned into clean events for the mode blocks.
//
//   Ports
//     clk      : system clock, rising edge
//     rst      : asynchronous active-high reset
//     key_n_i  : raw buttons, active low ([0]up [1]down [2]left [3]right
//                [4]enter [5]esc)
//     press_o  : one-cycle pulse per accepted press or auto-repeat
//     held_o   : debounced pressed level (1 = pressed)
//     any_o    : OR of held_o
//     long_o   : one-cycle long-press pulse (only with KEY_LONG_PRESS_EN,
//                otherwise constant 0)
//
//   Optional feature macro: KEY_LONG_PRESS_EN
// ---------------------------------------------------------------------------
module key_conditioner #(
    parameter int         DEB_CYCLES   = 20000,
    parameter int         REPEAT_DELAY = 500000,
    parameter int         REPEAT_RATE  = 100000,
    parameter logic [5:0] REPEAT_MASK  = 6'b000011,
    parameter int         LONG_CYCLES  = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] key_n_i,
    output logic [5:0] press_o,
    output logic [5:0] held_o,
    output logic       any_o,
    output logic [5:0] long_o
);

    localparam int MAX_A = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
    localparam int MAX_B = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
    localparam int MAX_P = (MAX_B > LONG_CYCLES) ? MAX_B : LONG_CYCLES;
    localparam int CW    = $clog2(MAX_P) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } state_t;

    // Synchroniser flops keep the raw (active-low) polarity so that their
    // reset value of 1 means "released".
    logic [5:0]    r_s1;
    logic [5:0]    r_s2;
    logic [5:0]    w_lvl;
    logic [5:0]    r_held;
    logic [CW-1:0] r_deb_cnt [6];
    logic [5:0]    w_toggle;
    logic [5:0]    w_rise;
    logic [5:0]    w_fall;

    state_t        r_state   [6];
    state_t        w_state_nxt [6];
    logic [CW-1:0] r_rep_cnt [6];
    logic [CW-1:0] w_rep_nxt [6];
    logic [5:0]    w_press_nxt;
    logic [5:0]    r_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= key_n_i;
            r_s2 <= r_s1;
        end
    end

    assign w_lvl = ~r_s2;

    // The counter runs while the synchronised level disagrees with the held
    // level; the level is accepted once the disagreement has persisted for
    // DEB_CYCLES samples beyond the first one, which puts a clean press on
    // held_o DEB_CYCLES+2 edges after it is first sampled.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            w_toggle[k] = (w_lvl[k] != r_held[k]) && (r_deb_cnt[k] == CW'(DEB_CYCLES));
        end
    end

    assign w_rise = w_toggle & ~r_held;
    assign w_fall = w_toggle & r_held;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held <= '0;
            for (int k = 0; k < 6; k++) begin
                r_deb_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (w_lvl[k] == r_held[k]) begin
                    r_deb_cnt[k] <= '0;
                end else if (w_toggle[k]) begin
                    r_held[k]    <= ~r_held[k];
                    r_deb_cnt[k] <= '0;
                end else begin
                    r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Per-key press / auto-repeat FSM, state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_press <= '0;
            for (int k = 0; k < 6; k++) begin
                r_state[k]   <= ST_IDLE;
                r_rep_cnt[k] <= '0;
            end
        end else begin
            r_press <= w_press_nxt;
            for (int k = 0; k < 6; k++) begin
                r_state[k]   <= w_state_nxt[k];
                r_rep_cnt[k] <= w_rep_nxt[k];
            end
        end
    end

    // Per-key FSM, next state and pulse. A release always wins over a repeat
    // that would fall on the same edge.
    always_comb begin
        w_press_nxt = '0;
        for (int k = 0; k < 6; k++) begin
            w_state_nxt[k] = r_state[k];
            w_rep_nxt[k]   = r_rep_cnt[k];
            if (w_fall[k]) begin
                w_state_nxt[k] = ST_IDLE;
                w_rep_nxt[k]   = '0;
            end else begin
                case (r_state[k])
                    ST_IDLE: begin
                        w_rep_nxt[k] = '0;
                        if (w_rise[k]) begin
                            w_press_nxt[k] = 1'b1;
                            w_state_nxt[k] = ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (REPEAT_MASK[k] && (r_rep_cnt[k] == CW'(REPEAT_DELAY - 1))) begin
                            w_press_nxt[k] = 1'b1;
                            w_state_nxt[k] = ST_REPEAT;
                            w_rep_nxt[k]   = '0;
                        end else if (r_rep_cnt[k] != '1) begin
                            w_rep_nxt[k] = r_rep_cnt[k] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (r_rep_cnt[k] == CW'(REPEAT_RATE - 1)) begin
                            w_press_nxt[k] = 1'b1;
                            w_rep_nxt[k]   = '0;
                        end else if (r_rep_cnt[k] != '1) begin
                            w_rep_nxt[k] = r_rep_cnt[k] + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt[k] = ST_IDLE;
                        w_rep_nxt[k]   = '0;
                    end
                endcase
            end
        end
    end

`ifdef KEY_LONG_PRESS_EN
    logic [CW-1:0] r_long_cnt [6];
    logic [5:0]    r_long;

    // long counter saturates at LONG_CYCLES so the pulse fires once per press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_long <= '0;
            for (int k = 0; k < 6; k++) begin
                r_long_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 6; k++) begin
                r_long[k] <= 1'b0;
                if (w_fall[k] || w_rise[k]) begin
                    r_long_cnt[k] <= '0;
                end else if (r_held[k] && (r_long_cnt[k] != CW'(LONG_CYCLES))) begin
                    if (r_long_cnt[k] == CW'(LONG_CYCLES - 1)) begin
                        r_long[k] <= 1'b1;
                    end
                    r_long_cnt[k] <= r_long_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign long_o = r_long;
`else
    assign long_o = '0;
`endif

    assign press_o = r_press;
    assign held_o  = r_held;
    assign any_o   = |r_held;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

    localparam int         DEB   = 4;
    localparam int         DLY   = 20;
    localparam int         RATE  = 8;
    localparam int         LONG  = 50;
    localparam logic [5:0] MASK  = 6'b000011;
    localparam int         HN    = 64;

    logic       clk;
    logic       rst;
    logic [5:0] key_n_i;
    logic [5:0] press_o;
    logic [5:0] held_o;
    logic       any_o;
    logic [5:0] long_o;

    int n_tests = 0;
    int n_fail  = 0;

    key_conditioner #(
        .DEB_CYCLES  (DEB),
        .REPEAT_DELAY(DLY),
        .REPEAT_RATE (RATE),
        .REPEAT_MASK (MASK),
        .LONG_CYCLES (LONG)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key_n_i(key_n_i),
        .press_o(press_o),
        .held_o (held_o),
        .any_o  (any_o),
        .long_o (long_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // A key's accepted level flips once the sampled pin has disagreed with
    // it for DEB+1 consecutive samples, the newest of which is two edges old.
    // Press pulses: at acceptance, then (masked keys) at DLY, DLY+RATE, ...
    // edges after acceptance while still held. Long pulse: LONG edges after.
    logic [5:0] hist [HN];
    int         ecnt     = 0;
    int         rst_edge = 0;
    int         m_p [6];
    logic [5:0] m_held = '0;
    logic [5:0] e_press = '0;
    logic [5:0] e_long  = '0;

    function automatic logic pressed_at(input int x, input int k);
        if (x < rst_edge) return 1'b0;
        return hist[x % HN][k];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_held   = '0;
            e_press  = '0;
            e_long   = '0;
            rst_edge = ecnt + 1;
        end else begin
            hist[ecnt % HN] = ~key_n_i;
            for (int k = 0; k < 6; k++) begin
                logic tog, was, stay;
                int   d;
                tog = 1'b1;
                for (int j = 2; j <= DEB + 2; j++) begin
                    if (pressed_at(ecnt - j, k) == m_held[k]) tog = 1'b0;
                end
                was  = m_held[k];
                stay = !tog && was;
                if (tog) m_held[k] = !was;
                e_press[k] = 1'b0;
                e_long[k]  = 1'b0;
                if (tog && !was) begin
                    m_p[k]     = ecnt;
                    e_press[k] = 1'b1;
                end else if (stay) begin
                    d = ecnt - m_p[k];
                    if (MASK[k] && d >= DLY && ((d - DLY) % RATE) == 0) e_press[k] = 1'b1;
`ifdef KEY_LONG_PRESS_EN
                    if (d == LONG) e_long[k] = 1'b1;
`endif
                end
            end
        end
        ecnt++;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            chk("press_rst", {26'd0, press_o}, 32'd0);
            chk("held_rst",  {26'd0, held_o},  32'd0);
            chk("any_rst",   {31'd0, any_o},   32'd0);
            chk("long_rst",  {26'd0, long_o},  32'd0);
        end else begin
            chk("press", {26'd0, press_o}, {26'd0, e_press});
            chk("held",  {26'd0, held_o},  {26'd0, m_held});
            chk("any",   {31'd0, any_o},   {31'd0, |m_held});
            chk("long",  {26'd0, long_o},  {26'd0, e_long});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int cnt;
        int idx;
        rst     = 1'b1;
        key_n_i = 6'b111111;
        tick(5);
        rst = 1'b0;
        tick(100);
        chk("idle_outputs", {press_o, held_o, long_o, any_o}, 32'd0);

        // clean press of up, held
        key_n_i[0] = 1'b0;
        for (int i = 0; i <= 43; i++) begin
            @(posedge clk); #1;
            chk("up_press_lit", {31'd0, press_o[0]},
                {31'd0, (i == 6 || i == 26 || i == 34 || i == 42)});
            if (i == 5) chk("up_held_before", {31'd0, held_o[0]}, 32'd0);
            if (i == 6) chk("up_held_at6",    {31'd0, held_o[0]}, 32'd1);
        end
        #1;
        // release: the repeat due at the falling edge must not appear
        key_n_i[0] = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(posedge clk); #1;
            chk("up_rel_held_lit",  {31'd0, held_o[0]},  {31'd0, (i < 6)});
            chk("up_rel_press_lit", {31'd0, press_o[0]}, 32'd0);
        end
        #1;
        tick(5);

        // enter bounces, then settles low
        cnt = 0;
        for (int r = 0; r < 6; r++) begin
            key_n_i[4] = 1'b0;
            for (int i = 0; i < 3; i++) begin tick(1); cnt += int'(press_o[4]); end
            key_n_i[4] = 1'b1;
            tick(1); cnt += int'(press_o[4]);
        end
        tick(4);
        chk("enter_bounce_held", {31'd0, held_o[4]}, 32'd0);
        chk("enter_bounce_press_cnt", cnt, 32'd0);
        key_n_i[4] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin tick(1); cnt += int'(press_o[4]); end
        chk("enter_one_press", cnt, 32'd1);
        key_n_i[4] = 1'b1;
        tick(10);

        // up and esc together
        key_n_i = 6'b011110;
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk); #1;
            chk("dual_press_lit", {26'd0, press_o}, (i == 6) ? 32'h21 : 32'd0);
            if (i == 6) chk("dual_any_lit", {31'd0, any_o}, 32'd1);
        end
        #1;
        key_n_i = 6'b111111;
        tick(10);

        // reset while down is held
        key_n_i[1] = 1'b0;
        tick(16);
        chk("down_held_pre_rst", {31'd0, held_o[1]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_immediate", {press_o, held_o, long_o, any_o}, 32'd0);
        #1;
        tick(3);
        rst = 1'b0;
        for (int i = 0; i <= 7; i++) begin
            @(posedge clk); #1;
            chk("down_after_rst_lit", {26'd0, press_o}, (i == 6) ? 32'h02 : 32'd0);
        end
        #1;
        key_n_i[1] = 1'b1;
        tick(10);

        // esc long hold
        key_n_i[5] = 1'b0;
        cnt = 0;
        for (int i = 0; i <= 60; i++) begin
            @(posedge clk); #1;
            cnt += int'(long_o[5]);
`ifdef KEY_LONG_PRESS_EN
            if (i == 56) chk("esc_long_lit", {31'd0, long_o[5]}, 32'd1);
`else
            if (i == 56) chk("esc_long_off_lit", {26'd0, long_o}, 32'd0);
`endif
        end
        #1;
`ifdef KEY_LONG_PRESS_EN
        chk("esc_long_count", cnt, 32'd1);
`else
        chk("esc_long_count", cnt, 32'd0);
`endif
        key_n_i[5] = 1'b1;
        tick(10);

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                tick($urandom_range(1, 3));
                rst = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) begin
                idx = $urandom_range(0, 5);
                key_n_i[idx] = ~key_n_i[idx];
            end
            tick(1);
        end
        key_n_i = 6'b111111;
        tick(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
